mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mymult.sv | 25 ++
 rtl/mult_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared widths, defaults and the issue-tag type for the multiplier arbiter.
package mult_pkg;

    localparam int unsigned NREQ_DEFAULT     = 2;
    localparam int unsigned MULT_LAT_DEFAULT = 3;
    localparam int unsigned OP_W             = 8;
    localparam int unsigned PROD_W           = 16;
    localparam int unsigned ID_W             = 4;

    // One entry of the issue-tracking pipeline.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    // Requester index that follows id, wrapping at n.
    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id, input int unsigned n);
        return ID_W'((32'(id) + 32'd1) % n);
    endfunction

endpackage

// File: rtl/mymult.sv
// 3-stage pipelined 8x8 unsigned multiplier; datapath-only, no reset.
module mymult
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   b_q;
    logic [PROD_W-1:0] prod_q;
    logic [PROD_W-1:0] out_q;

    always_ff @(posedge clk) begin
        a_q    <= a;
        b_q    <= b;
        prod_q <= PROD_W'(a_q) * PROD_W'(b_q);
        out_q  <= prod_q;
    end

    assign p = out_q;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NREQ requesters,
// with tag tracking to steer each product back to its issuer.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int unsigned NREQ     = NREQ_DEFAULT,
    parameter int unsigned MULT_LAT = MULT_LAT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*OP_W-1:0]   req_a,
    input  logic [NREQ*OP_W-1:0]   req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        res_valid,
    output logic [NREQ*PROD_W-1:0] res_data,
    output logic [1:0]             inflight
);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   grant_id;
    logic              granted;
    logic [OP_W-1:0]   mul_a;
    logic [OP_W-1:0]   mul_b;
    logic [PROD_W-1:0] mul_p;
    logic [1:0]        inflight_next;
    tag_t              tag_q [MULT_LAT];
    tag_t              out_tag;

    // First valid requester at or after the priority pointer wins.
    always_comb begin
        granted   = 1'b0;
        grant_id  = '0;
        req_ready = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (en && !granted && req_valid[i] && (((32'(ptr) + k) % NREQ) == i)) begin
                    granted  = 1'b1;
                    grant_id = ID_W'(i);
                end
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready[i] = granted && (grant_id == ID_W'(i));
        end
    end

    // Operand mux; idle cycles feed zeros into the multiplier.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                mul_a = req_a[i*OP_W +: OP_W];
                mul_b = req_b[i*OP_W +: OP_W];
            end
        end
    end

    mymult u_mult (
        .clk (clk),
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p)
    );

    // Pointer moves past the winner only when a handshake happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (granted) begin
            ptr <= rr_next(grant_id, NREQ);
        end
    end

    // Tag pipeline mirrors the multiplier stages and never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MULT_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: granted, id: grant_id};
            for (int unsigned i = 1; i < MULT_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Occupancy after the next edge: new issue plus tags not yet retiring.
    always_comb begin
        inflight_next = 2'(granted);
        for (int unsigned i = 0; i + 1 < MULT_LAT; i++) begin
            inflight_next = inflight_next + 2'(tag_q[i].valid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            inflight <= inflight_next;
        end
    end

    assign out_tag = tag_q[MULT_LAT-1];

    // Capture the product only when the aligned tag is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= '0;
            res_data  <= '0;
        end else begin
            res_valid <= '0;
            if (out_tag.valid) begin
                for (int unsigned i = 0; i < NREQ; i++) begin
                    if (out_tag.id == ID_W'(i)) begin
                        res_valid[i]                     <= 1'b1;
                        res_data[i*PROD_W +: PROD_W]     <= mul_p;
                    end
                end
            end
        end
    end

endmodule
